// File: rtl/bg_fetch_sched.sv
// bg_fetch_sched: background-graphic SDRAM scheduler (clk_sys domain).
// Shares one SDRAM channel between the HPS download writer (bytes packed
// into 16-bit writes) and a small 32-bit prefetch FIFO that feeds one RGBA
// word per visible pixel. One transaction is outstanding at a time and
// writes always win.
// Optional feature macro: BG_UNDERRUN_CNT_EN (FIFO underrun counter).
module bg_fetch_sched #(
  parameter int FIFO_AW   = 3,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        sdram_ok,
  input  logic        ce_pix,
  input  logic        de,
  input  logic        vs,
  output logic [23:0] ch_addr,
  output logic [15:0] ch_din,
  output logic        ch_req,
  output logic        ch_rnw,
  input  logic [31:0] ch_dout,
  input  logic        ch_ack,
  output logic [31:0] bg_rgba,
  output logic        bg_en,
  output logic        dl_ovf,
  output logic [15:0] underrun_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW+1:0] GATE_ONE = {{(FIFO_AW+1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW+1:0] LOW_WATER_C = (FIFO_AW+2)'(LOW_WATER);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // Edge detect and enable state
  logic        dl_active_q;
  logic        vs_q;
  logic        bg_en_q;

  // Download byte packing
  logic [7:0]  lo_byte_q;
  logic        wr_pend_q;
  logic [23:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        dl_ovf_q;

  // Channel scheduler
  state_t      state_q;
  logic        ch_req_q;
  logic        ch_rnw_q;
  logic [23:0] ch_addr_q;
  logic [15:0] ch_din_q;
  logic [23:0] rd_addr_q;
  logic        epoch_q;
  logic        rd_epoch_q;

  // Prefetch FIFO
  logic [31:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] fifo_wp_q, fifo_wp_d;
  logic [FIFO_AW-1:0] fifo_rp_q, fifo_rp_d;
  logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;

  logic [31:0] bg_rgba_q;

  // Decoded events
  logic vs_rise_s;
  logic flush_s;
  logic pair_done_s;
  logic wr_done_s;
  logic rd_done_s;
  logic rd_fresh_s;
  logic push_s;
  logic fifo_empty_s;
  logic pop_req_s;
  logic pop_s;
  logic underrun_s;
  logic rd_gate_s;

  assign vs_rise_s    = vs & ~vs_q;
  // Frame restart and an active download both empty the prefetch FIFO.
  assign flush_s      = vs_rise_s | dl_active;
  assign pair_done_s  = dl_wr & dl_addr[0];
  assign wr_done_s    = (state_q == WR_WAIT) & ch_ack;
  assign rd_done_s    = (state_q == RD_WAIT) & ch_ack;
  // A read issued before the latest frame restart belongs to a stale epoch.
  assign rd_fresh_s   = rd_done_s & (rd_epoch_q == epoch_q);
  assign push_s       = rd_fresh_s & ~flush_s;
  assign fifo_empty_s = (fifo_cnt_q == CNT_ZERO);
  assign pop_req_s    = ce_pix & de & bg_en_q & ~dl_active;
  assign pop_s        = pop_req_s & ~fifo_empty_s;
  assign underrun_s   = pop_req_s & fifo_empty_s;
  // The +1 reserves room for the read about to be issued, so a push can
  // never land in a full FIFO.
  assign rd_gate_s    = bg_en_q & ~dl_active &
                        (({1'b0, fifo_cnt_q} + GATE_ONE) < LOW_WATER_C);

  // Track dl_active/vs history and latch bg_en at the end of a download.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_active_q <= 1'b0;
      vs_q        <= 1'b0;
      bg_en_q     <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      vs_q        <= vs;
      if (dl_active_q && !dl_active && sdram_ok) begin
        bg_en_q <= 1'b1;
      end
    end
  end

  // Pack download bytes into 16-bit writes; a pair arriving while the
  // previous write is still pending is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_byte_q <= 8'h00;
      wr_pend_q <= 1'b0;
      wr_addr_q <= 24'h000000;
      wr_data_q <= 16'h0000;
      dl_ovf_q  <= 1'b0;
    end else begin
      if (dl_wr && !dl_addr[0]) begin
        lo_byte_q <= dl_data;
      end
      if (pair_done_s && !wr_pend_q) begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= dl_addr[24:1];
        wr_data_q <= {dl_data, lo_byte_q};
      end else if (wr_done_s) begin
        wr_pend_q <= 1'b0;
      end
      if (pair_done_s && wr_pend_q) begin
        dl_ovf_q <= 1'b1;
      end
    end
  end

  // Channel scheduler: issue one registered request from IDLE, wait for its
  // ack; also owns the read address and the frame epoch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_req_q   <= 1'b0;
      ch_rnw_q   <= 1'b0;
      ch_addr_q  <= 24'h000000;
      ch_din_q   <= 16'h0000;
      rd_addr_q  <= 24'h000000;
      epoch_q    <= 1'b0;
      rd_epoch_q <= 1'b0;
    end else begin
      ch_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_pend_q) begin
            ch_req_q  <= 1'b1;
            ch_rnw_q  <= 1'b0;
            ch_addr_q <= wr_addr_q;
            ch_din_q  <= wr_data_q;
            state_q   <= WR_WAIT;
          end else if (rd_gate_s) begin
            ch_req_q   <= 1'b1;
            ch_rnw_q   <= 1'b1;
            ch_addr_q  <= rd_addr_q;
            rd_epoch_q <= epoch_q;
            state_q    <= RD_WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WR_WAIT: begin
          if (ch_ack) begin
            state_q <= IDLE;
          end else begin
            state_q <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (ch_ack) begin
            state_q <= IDLE;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Stale reads do not advance the address so a restarted frame
      // always begins at word 0.
      if (vs_rise_s) begin
        rd_addr_q <= 24'h000000;
        epoch_q   <= ~epoch_q;
      end else if (rd_fresh_s) begin
        rd_addr_q <= rd_addr_q + 24'd2;
      end
    end
  end

  // FIFO pointer/count next state; flush overrides push and pop.
  always_comb begin
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush_s) begin
      fifo_wp_d  = {FIFO_AW{1'b0}};
      fifo_rp_d  = {FIFO_AW{1'b0}};
      fifo_cnt_d = CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_wp_d = fifo_wp_q + PTR_ONE;
      end else begin
        fifo_wp_d = fifo_wp_q;
      end
      if (pop_s) begin
        fifo_rp_d = fifo_rp_q + PTR_ONE;
      end else begin
        fifo_rp_d = fifo_rp_q;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // FIFO pointer/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wp_q  <= {FIFO_AW{1'b0}};
      fifo_rp_q  <= {FIFO_AW{1'b0}};
      fifo_cnt_q <= CNT_ZERO;
    end else begin
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[fifo_wp_q] <= ch_dout;
    end
  end

  // Pixel output: popped word, transparent on underrun or when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bg_rgba_q <= 32'h00000000;
    end else if (!bg_en_q || dl_active) begin
      bg_rgba_q <= 32'h00000000;
    end else if (pop_s) begin
      bg_rgba_q <= fifo_mem[fifo_rp_q];
    end else if (underrun_s) begin
      bg_rgba_q <= 32'h00000000;
    end
  end

`ifdef BG_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  // Saturating per-frame count of pops that found the FIFO empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= 16'h0000;
    end else if (vs_rise_s) begin
      underrun_q <= 16'h0000;
    end else if (underrun_s && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

  assign ch_addr = ch_addr_q;
  assign ch_din  = ch_din_q;
  assign ch_req  = ch_req_q;
  assign ch_rnw  = ch_rnw_q;
  assign bg_rgba = bg_rgba_q;
  assign bg_en   = bg_en_q;
  assign dl_ovf  = dl_ovf_q;

endmodule

// File: tb/tb_bg_fetch_sched.sv
// Self-checking bench for bg_fetch_sched: table-driven byte packing plus
// hand-written sequences for overflow, streaming, frame restart, write
// priority, underrun and reset mid-transaction. An SDRAM model answers
// each request after a programmable latency; read data is A0000001+addr/2.
`timescale 1ns/1ps
module tb_bg_fetch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_active, dl_wr, sdram_ok, ce_pix, de, vs;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [23:0] ch_addr;
  logic [15:0] ch_din;
  logic        ch_req, ch_rnw, ch_ack;
  logic [31:0] ch_dout;
  logic [31:0] bg_rgba;
  logic        bg_en, dl_ovf;
  logic [15:0] underrun_cnt;

  int n_pass = 0;
  int n_total = 0;

`ifdef BG_UNDERRUN_CNT_EN
  localparam logic [31:0] UR_EXP = 32'd5;
`else
  localparam logic [31:0] UR_EXP = 32'd0;
`endif

  bg_fetch_sched dut (
    .clk(clk), .reset(rst), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .sdram_ok(sdram_ok),
    .ce_pix(ce_pix), .de(de), .vs(vs), .ch_addr(ch_addr), .ch_din(ch_din),
    .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_dout(ch_dout), .ch_ack(ch_ack),
    .bg_rgba(bg_rgba), .bg_en(bg_en), .dl_ovf(dl_ovf),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return 32'hA0000001 + {9'd0, a[23:1]};
  endfunction

  // SDRAM model and request log
  int          lat = 3;
  bit          ack_hold = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  int          pend_idx = 0;
  logic [23:0] pend_addr;
  logic        pend_rnw;
  logic [23:0] log_addr [0:255];
  logic [15:0] log_din  [0:255];
  logic        log_rnw  [0:255];
  int unsigned log_cyc  [0:255];
  int unsigned log_ack  [0:255];
  int          log_n = 0;

  initial begin
    ch_ack = 1'b0;
    ch_dout = 32'h0;
    forever begin
      @(posedge clk); #1;
      ch_ack = 1'b0;
      if (pend && !ack_hold) begin
        if (pend_cnt <= 1) begin
          ch_ack = 1'b1;
          ch_dout = pend_rnw ? word_at(pend_addr) : 32'h0;
          log_ack[pend_idx] = cyc;
          pend = 1'b0;
        end else begin
          pend_cnt = pend_cnt - 1;
        end
      end
      if (ch_req && log_n < 256) begin
        log_addr[log_n] = ch_addr;
        log_din[log_n]  = ch_din;
        log_rnw[log_n]  = ch_rnw;
        log_cyc[log_n]  = cyc;
        log_ack[log_n]  = 0;
        pend = 1'b1;
        pend_cnt = lat;
        pend_addr = ch_addr;
        pend_rnw = ch_rnw;
        pend_idx = log_n;
        log_n = log_n + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},  {31'd0, ch_req}, 32'd0);
    check({tag, "_rnw"},  {31'd0, ch_rnw}, 32'd0);
    check({tag, "_addr"}, {8'd0, ch_addr}, 32'd0);
    check({tag, "_din"},  {16'd0, ch_din}, 32'd0);
    check({tag, "_rgba"}, bg_rgba, 32'd0);
    check({tag, "_en"},   {31'd0, bg_en}, 32'd0);
    check({tag, "_ovf"},  {31'd0, dl_ovf}, 32'd0);
    check({tag, "_ur"},   {16'd0, underrun_cnt}, 32'd0);
  endtask

  task automatic pop_once(input logic [31:0] exp, input string nm);
    ce_pix = 1'b1; de = 1'b1;
    tick();
    check(nm, bg_rgba, exp);
    ce_pix = 1'b0; de = 1'b0;
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [23:0] exp_addr;
    logic [15:0] exp_din;
  } pk_vec_t;

  pk_vec_t pk_tbl [0:3];

  initial begin
    int base;
    int base_rd;
    bit found;

    pk_tbl[0] = '{25'h0000000, 8'h11, 8'h22, 24'h000000, 16'h2211};
    pk_tbl[1] = '{25'h0000010, 8'hAB, 8'hCD, 24'h000008, 16'hCDAB};
    pk_tbl[2] = '{25'h1FFFFFE, 8'h5A, 8'hA5, 24'hFFFFFF, 16'hA55A};
    pk_tbl[3] = '{25'h00ABCDE, 8'h00, 8'hFF, 24'h055E6F, 16'hFF00};

    rst = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0;
    dl_data = 8'd0; sdram_ok = 1'b1; ce_pix = 1'b0; de = 1'b0; vs = 1'b0;
    ticks(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Byte packing table
    dl_active = 1'b1;
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      base = log_n;
      dl_wr = 1'b1; dl_addr = pk_tbl[i].addr; dl_data = pk_tbl[i].lo;
      tick();
      dl_addr = pk_tbl[i].addr | 25'd1; dl_data = pk_tbl[i].hi;
      tick();
      dl_wr = 1'b0;
      ticks(10);
      check("pk_nreq", log_n - base, 32'd1);
      check("pk_rnw",  {31'd0, log_rnw[base]}, 32'd0);
      check("pk_addr", {8'd0, log_addr[base]}, {8'd0, pk_tbl[i].exp_addr});
      check("pk_din",  {16'd0, log_din[base]}, {16'd0, pk_tbl[i].exp_din});
    end
    check("pk_ovf_clear", {31'd0, dl_ovf}, 32'd0);

    // Overflow: second pair arrives while the first write is unacked
    ack_hold = 1'b1;
    base = log_n;
    dl_wr = 1'b1;
    dl_addr = 25'h2; dl_data = 8'h33; tick();
    dl_addr = 25'h3; dl_data = 8'h44; tick();
    dl_addr = 25'h4; dl_data = 8'h55; tick();
    dl_addr = 25'h5; dl_data = 8'h66; tick();
    dl_wr = 1'b0;
    ticks(2);
    check("ovf_set", {31'd0, dl_ovf}, 32'd1);
    ack_hold = 1'b0;
    ticks(12);
    check("ovf_nreq", log_n - base, 32'd1);
    check("ovf_addr", {8'd0, log_addr[base]}, 32'd1);
    check("ovf_din",  {16'd0, log_din[base]}, 32'h4433);
    check("ovf_sticky", {31'd0, dl_ovf}, 32'd1);

    // bg_en on download end, then prefetch and stream
    check("en_during_dl", {31'd0, bg_en}, 32'd0);
    lat = 4;
    base_rd = log_n;
    dl_active = 1'b0;
    tick();
    check("en_set", {31'd0, bg_en}, 32'd1);
    ticks(30);
    for (int k = 0; k < 16; k++) begin
      pop_once(32'hA0000001 + k, "stream_pix");
      for (int j = 0; j < 7; j++) begin
        ce_pix = (j % 2) == 1;
        tick();
      end
      ce_pix = 1'b0;
      if (k == 0) check("stream_hold", bg_rgba, 32'hA0000001);
    end
    ticks(20);
    check("stream_nrd", log_n - base_rd, 32'd19);
    for (int k = 0; k < 16; k++) begin
      check("stream_req", {7'd0, log_rnw[base_rd + k], log_addr[base_rd + k]},
            {8'h01, 24'(2 * k)});
    end

    // Frame restart while a read is in flight
    pop_once(32'hA0000011, "rs_pre_pix");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ch_req && ch_rnw) found = 1'b1;
    end
    check("rs_req_seen", {31'd0, found}, 32'd1);
    check("rs_req_addr", {8'd0, ch_addr}, 32'd38);
    base = log_n;
    vs = 1'b1;
    ticks(30);
    check("rs_next_req", {7'd0, log_rnw[base], log_addr[base]}, 32'h01000000);
    pop_once(32'hA0000001, "rs_first_pix");
    vs = 1'b0;
    ticks(20);

    // Write priority: write and read both eligible in the same IDLE cycle
    lat = 3;
    base = log_n;
    dl_wr = 1'b1; dl_addr = 25'h100; dl_data = 8'h77;
    tick();
    dl_addr = 25'h101; dl_data = 8'h88; ce_pix = 1'b1; de = 1'b1;
    tick();
    check("pri_pix", bg_rgba, 32'hA0000002);
    dl_wr = 1'b0; ce_pix = 1'b0; de = 1'b0;
    ticks(15);
    check("pri_nreq", log_n - base, 32'd2);
    check("pri_first", {7'd0, log_rnw[base], log_addr[base]}, 32'h00000080);
    check("pri_din", {16'd0, log_din[base]}, 32'h8877);
    check("pri_second", {7'd0, log_rnw[base + 1], log_addr[base + 1]}, 32'h01000008);
    check("pri_gap", log_cyc[base + 1] - log_ack[base], 32'd2);

    // Underrun: reads never complete after a frame restart
    ack_hold = 1'b1;
    ticks(2);
    vs = 1'b1; tick();
    vs = 1'b0; ticks(4);
    for (int k = 0; k < 5; k++) begin
      pop_once(32'h0, "ur_pix");
      tick();
    end
    check("ur_cnt", {16'd0, underrun_cnt}, UR_EXP);
    vs = 1'b1; tick();
    check("ur_vs_clear", {16'd0, underrun_cnt}, 32'd0);
    vs = 1'b0; tick();

    // Reset with a read outstanding; the late ack must be ignored
    base = log_n;
    rst = 1'b1;
    ticks(2);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    tick();
    ack_hold = 1'b0;
    ticks(10);
    check("rst_no_req", log_n - base, 32'd0);
    dl_active = 1'b1; ticks(2);
    dl_active = 1'b0; ticks(30);
    check("rst_en", {31'd0, bg_en}, 32'd1);
    check("rst_first_req", {7'd0, log_rnw[base], log_addr[base]}, 32'h01000000);
    pop_once(32'hA0000001, "rst_first_pix");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
